// File: rtl/st7735_spi_sink_if.sv
// SPI pins of an ST7735 panel link plus the decoded pixel/command stream.
// The master side drives the pins and watches the stream; the sink is the slave.
interface st7735_spi_sink_if #(
  parameter int C_x_size = 128,
  parameter int C_y_size = 160,
  parameter int C_x_bits = $clog2(C_x_size),
  parameter int C_y_bits = $clog2(C_y_size)
);
  logic                oled_csn;
  logic                oled_clk;
  logic                oled_mosi;
  logic                oled_dc;
  logic                oled_resn;
  logic [C_x_bits-1:0] x;
  logic [C_y_bits-1:0] y;
  logic [15:0]         color;
  logic                pixel_valid;
  logic [7:0]          cmd;
  logic                cmd_valid;

  modport master (
    output oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
    input  x, y, color, pixel_valid, cmd, cmd_valid
  );

  modport slave (
    input  oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
    output x, y, color, pixel_valid, cmd, cmd_valid
  );
endinterface

// File: rtl/st7735_spi_sink.sv
// ST7735 SPI receiver: decodes CASET/RASET/RAMWR and emits one strobe per RGB565 pixel.
// Define ST7735_SINK_MADCTL_EN to honour MADCTL (0x36) MX/MY output mirroring.
module st7735_spi_sink #(
  parameter int C_x_size = 128,
  parameter int C_y_size = 160,
  parameter int C_x_bits = $clog2(C_x_size),
  parameter int C_y_bits = $clog2(C_y_size)
) (
  input logic               clk,
  input logic               resetn,
  st7735_spi_sink_if.slave  bus
);

  localparam logic [C_x_bits-1:0] X_LAST = C_x_bits'(C_x_size - 1);
  localparam logic [C_y_bits-1:0] Y_LAST = C_y_bits'(C_y_size - 1);

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
`ifdef ST7735_SINK_MADCTL_EN
  localparam logic [7:0] CMD_MADCTL = 8'h36;
`endif

  // Lane order of the synchronizer: {resn, dc, mosi, sclk, csn}; csn/resn idle high.
  localparam int           L_CSN  = 0;
  localparam int           L_SCLK = 1;
  localparam int           L_MOSI = 2;
  localparam int           L_DC   = 3;
  localparam int           L_RESN = 4;
  localparam logic [4:0]   SYNC_IDLE = 5'b10001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CASET,
    ST_RASET,
    ST_RAMWR,
    ST_MADCTL
  } state_t;

  logic [4:0] pins;
  logic [4:0] meta_reg;
  logic [4:0] sync_reg;
  logic       sclk_d_reg;
  logic       csn_d_reg;

  logic       csn_s;
  logic       mosi_s;
  logic       dc_s;
  logic       resn_s;
  logic       sclk_rise;
  logic       bit_take;

  logic [2:0] bit_cnt_reg;
  logic [6:0] shift_reg;
  logic       byte_done_reg;
  logic [7:0] byte_reg;
  logic       byte_dc_reg;

  state_t              state_reg,   state_next;
  logic [2:0]          arg_cnt_reg, arg_cnt_next;
  logic [7:0]          arg_hi_reg,  arg_hi_next;
  logic [15:0]         start_reg,   start_next;
  logic [C_x_bits-1:0] xs_reg, xs_next, xe_reg, xe_next, x_reg, x_next;
  logic [C_y_bits-1:0] ys_reg, ys_next, ye_reg, ye_next, y_reg, y_next;
  logic [7:0]          hi_byte_reg, hi_byte_next;
  logic                phase_reg,   phase_next;
  logic [1:0]          madctl_reg,  madctl_next;

  logic [C_x_bits-1:0] x_out_reg, x_out_next;
  logic [C_y_bits-1:0] y_out_reg, y_out_next;
  logic [15:0]         color_reg, color_next;
  logic                pixel_valid_reg, pixel_valid_next;
  logic [7:0]          cmd_reg, cmd_next;
  logic                cmd_valid_reg, cmd_valid_next;

  logic [15:0]         arg_word;
  logic [C_x_bits-1:0] x_wr;
  logic [C_y_bits-1:0] y_wr;
  logic                unused_bits;

  assign pins = {bus.oled_resn, bus.oled_dc, bus.oled_mosi, bus.oled_clk, bus.oled_csn};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_reg   <= SYNC_IDLE;
      sync_reg   <= SYNC_IDLE;
      sclk_d_reg <= 1'b0;
      csn_d_reg  <= 1'b1;
    end else begin
      meta_reg   <= pins;
      sync_reg   <= meta_reg;
      sclk_d_reg <= sync_reg[L_SCLK];
      csn_d_reg  <= sync_reg[L_CSN];
    end
  end

  assign csn_s     = sync_reg[L_CSN];
  assign mosi_s    = sync_reg[L_MOSI];
  assign dc_s      = sync_reg[L_DC];
  assign resn_s    = sync_reg[L_RESN];
  assign sclk_rise = sync_reg[L_SCLK] & ~sclk_d_reg;
  // Gate on the previous csn so an 8th bit landing with the csn rise still completes.
  assign bit_take  = sclk_rise & ~csn_d_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 7'd0;
      byte_done_reg <= 1'b0;
      byte_reg      <= 8'd0;
      byte_dc_reg   <= 1'b0;
    end else if (!resn_s) begin
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 7'd0;
      byte_done_reg <= 1'b0;
      byte_reg      <= 8'd0;
      byte_dc_reg   <= 1'b0;
    end else begin
      byte_done_reg <= 1'b0;
      if (bit_take) begin
        shift_reg <= {shift_reg[5:0], mosi_s};
        if (bit_cnt_reg == 3'd7) begin
          bit_cnt_reg   <= 3'd0;
          byte_done_reg <= 1'b1;
          byte_reg      <= {shift_reg, mosi_s};
          byte_dc_reg   <= dc_s;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
      end
      if (csn_s) begin
        bit_cnt_reg <= 3'd0;
        shift_reg   <= 7'd0;
      end
    end
  end

  assign arg_word    = {arg_hi_reg, byte_reg};
  assign unused_bits = ^{arg_word, start_reg};

`ifdef ST7735_SINK_MADCTL_EN
  assign x_wr = madctl_reg[0] ? (X_LAST - x_reg) : x_reg;
  assign y_wr = madctl_reg[1] ? (Y_LAST - y_reg) : y_reg;
`else
  assign x_wr = x_reg;
  assign y_wr = y_reg;
`endif

  always_comb begin
    state_next       = state_reg;
    arg_cnt_next     = arg_cnt_reg;
    arg_hi_next      = arg_hi_reg;
    start_next       = start_reg;
    xs_next          = xs_reg;
    xe_next          = xe_reg;
    ys_next          = ys_reg;
    ye_next          = ye_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    hi_byte_next     = hi_byte_reg;
    phase_next       = phase_reg;
    madctl_next      = madctl_reg;
    x_out_next       = x_out_reg;
    y_out_next       = y_out_reg;
    color_next       = color_reg;
    pixel_valid_next = 1'b0;
    cmd_next         = cmd_reg;
    cmd_valid_next   = 1'b0;

    if (byte_done_reg) begin
      if (!byte_dc_reg) begin
        cmd_next       = byte_reg;
        cmd_valid_next = 1'b1;
        arg_cnt_next   = 3'd0;
        phase_next     = 1'b0;
        case (byte_reg)
          CMD_CASET: state_next = ST_CASET;
          CMD_RASET: state_next = ST_RASET;
          CMD_RAMWR: begin
            state_next = ST_RAMWR;
            x_next     = xs_reg;
            y_next     = ys_reg;
          end
`ifdef ST7735_SINK_MADCTL_EN
          CMD_MADCTL: state_next = ST_MADCTL;
`endif
          default:   state_next = ST_SKIP;
        endcase
      end else begin
        // Saturate at 4 so any trailing argument bytes fall through harmlessly.
        if (arg_cnt_reg != 3'd4) begin
          arg_cnt_next = arg_cnt_reg + 3'd1;
        end
        case (state_reg)
          ST_CASET, ST_RASET: begin
            case (arg_cnt_reg)
              3'd0, 3'd2: arg_hi_next = byte_reg;
              3'd1:       start_next  = arg_word;
              3'd3: begin
                if (state_reg == ST_CASET) begin
                  xs_next = start_reg[C_x_bits-1:0];
                  xe_next = arg_word[C_x_bits-1:0];
                end else begin
                  ys_next = start_reg[C_y_bits-1:0];
                  ye_next = arg_word[C_y_bits-1:0];
                end
              end
              default: ;
            endcase
          end
          ST_RAMWR: begin
            if (!phase_reg) begin
              hi_byte_next = byte_reg;
              phase_next   = 1'b1;
            end else begin
              phase_next       = 1'b0;
              pixel_valid_next = 1'b1;
              color_next       = {hi_byte_reg, byte_reg};
              x_out_next       = x_wr;
              y_out_next       = y_wr;
              if (x_reg == xe_reg) begin
                x_next = xs_reg;
                y_next = (y_reg == ye_reg) ? ys_reg : y_reg + 1'b1;
              end else begin
                x_next = x_reg + 1'b1;
              end
            end
          end
          ST_MADCTL: begin
            if (arg_cnt_reg == 3'd0) begin
              madctl_next = byte_reg[7:6];
            end
          end
          default: ;
        endcase
      end
    end

    // Panel reset pin behaves like a synchronous copy of resetn for the decoder.
    if (!resn_s) begin
      state_next       = ST_IDLE;
      arg_cnt_next     = 3'd0;
      arg_hi_next      = 8'd0;
      start_next       = 16'd0;
      xs_next          = '0;
      xe_next          = X_LAST;
      ys_next          = '0;
      ye_next          = Y_LAST;
      x_next           = '0;
      y_next           = '0;
      hi_byte_next     = 8'd0;
      phase_next       = 1'b0;
      madctl_next      = 2'd0;
      x_out_next       = '0;
      y_out_next       = '0;
      color_next       = 16'd0;
      pixel_valid_next = 1'b0;
      cmd_next         = 8'd0;
      cmd_valid_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      arg_cnt_reg     <= 3'd0;
      arg_hi_reg      <= 8'd0;
      start_reg       <= 16'd0;
      xs_reg          <= '0;
      xe_reg          <= X_LAST;
      ys_reg          <= '0;
      ye_reg          <= Y_LAST;
      x_reg           <= '0;
      y_reg           <= '0;
      hi_byte_reg     <= 8'd0;
      phase_reg       <= 1'b0;
      madctl_reg      <= 2'd0;
      x_out_reg       <= '0;
      y_out_reg       <= '0;
      color_reg       <= 16'd0;
      pixel_valid_reg <= 1'b0;
      cmd_reg         <= 8'd0;
      cmd_valid_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      arg_cnt_reg     <= arg_cnt_next;
      arg_hi_reg      <= arg_hi_next;
      start_reg       <= start_next;
      xs_reg          <= xs_next;
      xe_reg          <= xe_next;
      ys_reg          <= ys_next;
      ye_reg          <= ye_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      hi_byte_reg     <= hi_byte_next;
      phase_reg       <= phase_next;
      madctl_reg      <= madctl_next;
      x_out_reg       <= x_out_next;
      y_out_reg       <= y_out_next;
      color_reg       <= color_next;
      pixel_valid_reg <= pixel_valid_next;
      cmd_reg         <= cmd_next;
      cmd_valid_reg   <= cmd_valid_next;
    end
  end

  assign bus.x           = x_out_reg;
  assign bus.y           = y_out_reg;
  assign bus.color       = color_reg;
  assign bus.pixel_valid = pixel_valid_reg;
  assign bus.cmd         = cmd_reg;
  assign bus.cmd_valid   = cmd_valid_reg;

endmodule

// File: tb/tb_st7735_spi_sink.sv
// Directed bench for st7735_spi_sink: drives SPI bytes and checks the decoded pixel/command strobes.
// A reduced 8x10 panel keeps the full-frame walk short while exercising both wrap paths.
`timescale 1ns/1ps
module tb_st7735_spi_sink;
  localparam int XS = 8;
  localparam int YS = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  st7735_spi_sink_if #(.C_x_size(XS), .C_y_size(YS)) bus ();

  st7735_spi_sink #(.C_x_size(XS), .C_y_size(YS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          checks_total  = 0;
  int          checks_passed = 0;
  logic [31:0] cyc = 0;
  logic [31:0] last_rise = 0;
  logic [31:0] px_q[$];
  logic [31:0] px_t[$];
  logic [31:0] cmd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture strobes as packed {x[7:0], y[7:0], color[15:0]} with their cycle stamp.
  always @(negedge clk) begin
    if (bus.pixel_valid === 1'b1) begin
      px_q.push_back({8'(bus.x), 8'(bus.y), bus.color});
      px_t.push_back(cyc);
    end
    if (bus.cmd_valid === 1'b1) cmd_q.push_back({24'd0, bus.cmd});
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
  endtask

  task automatic check_px(input string tag, input int ex, input int ey, input int ec);
    logic [31:0] obs;
    obs = 32'hFFFF_FFFF;
    if (px_q.size() > 0) obs = px_q.pop_front();
    check(tag, obs, {8'(ex), 8'(ey), 16'(ec)});
  endtask

  task automatic clear_q();
    px_q.delete();
    px_t.delete();
    cmd_q.delete();
  endtask

  // Mode 0, MSB first, 6 clk per bit (3 low, 3 high).
  task automatic spi_bits(input logic dc, input logic [7:0] val, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      bus.oled_mosi = val[i];
      bus.oled_dc   = dc;
      repeat (2) @(negedge clk);
      bus.oled_clk = 1'b1;
      last_rise    = cyc;
      repeat (3) @(negedge clk);
      bus.oled_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    spi_bits(1'b0, c, 8);
  endtask

  task automatic send_dat(input logic [7:0] d);
    spi_bits(1'b1, d, 8);
  endtask

  task automatic send_px(input logic [15:0] c);
    send_dat(c[15:8]);
    send_dat(c[7:0]);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    bus.oled_csn  = 1'b1;
    bus.oled_clk  = 1'b0;
    bus.oled_mosi = 1'b0;
    bus.oled_dc   = 1'b0;
    bus.oled_resn = 1'b1;
    resetn        = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pixel_valid", {31'd0, bus.pixel_valid}, 32'd0);
    check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_color", 32'(bus.color), 32'd0);
    check("rst_cmd", 32'(bus.cmd), 32'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    bus.oled_csn = 1'b0;
    repeat (3) @(negedge clk);

    // Default window: first pixel at (0,0), strobe 4 clk after the last sclk rise.
    clear_q();
    send_cmd(8'h2C);
    send_px(16'hF800);
    settle();
    check("def_cmd_count", cmd_q.size(), 1);
    check("def_cmd", (cmd_q.size() > 0) ? cmd_q[0] : 32'hFFFF_FFFF, 32'h2C);
    check("def_px_count", px_q.size(), 1);
    check("def_latency", (px_t.size() > 0) ? px_t[0] - last_rise : 32'hFFFF_FFFF, 32'd4);
    check_px("def_px", 0, 0, 16'hF800);

    // 2x2 window with wrap back to its origin.
    clear_q();
    send_cmd(8'h2A); send_dat(8'h00); send_dat(8'h02); send_dat(8'h00); send_dat(8'h03);
    send_cmd(8'h2B); send_dat(8'h00); send_dat(8'h05); send_dat(8'h00); send_dat(8'h06);
    send_cmd(8'h2C);
    for (int i = 1; i <= 5; i++) send_px(16'(i));
    settle();
    check("win_cmd_count", cmd_q.size(), 3);
    check_px("win_px1", 2, 5, 1);
    check_px("win_px2", 3, 5, 2);
    check_px("win_px3", 2, 6, 3);
    check_px("win_px4", 3, 6, 4);
    check_px("win_px5", 2, 5, 5);
    check("win_extra", px_q.size(), 0);

    // Full frame, then one more pixel wraps to (0,0).
    clear_q();
    send_cmd(8'h2A); send_dat(8'h00); send_dat(8'h00); send_dat(8'h00); send_dat(8'h07);
    send_cmd(8'h2B); send_dat(8'h00); send_dat(8'h00); send_dat(8'h00); send_dat(8'h09);
    send_cmd(8'h2C);
    for (int i = 0; i <= XS * YS; i++) send_px(16'(i));
    settle();
    check("frame_count", px_q.size(), XS * YS + 1);
    for (int i = 0; i < XS * YS; i++) check_px($sformatf("frame_px%0d", i), i % XS, i / XS, i);
    check_px("frame_wrap", 0, 0, XS * YS);

    // Pending high byte dropped by a new command.
    clear_q();
    send_cmd(8'h2C);
    send_dat(8'hAB);
    send_cmd(8'h2C);
    send_px(16'h1234);
    settle();
    check("abort_count", px_q.size(), 1);
    check_px("abort_px", 0, 0, 16'h1234);

    // csn pulse after 4 bits discards the partial byte; RAMWR continues at (1,0).
    clear_q();
    spi_bits(1'b1, 8'hF0, 4);
    @(negedge clk);
    bus.oled_csn = 1'b1;
    repeat (4) @(negedge clk);
    bus.oled_csn = 1'b0;
    repeat (3) @(negedge clk);
    send_px(16'h5678);
    settle();
    check("csn_abort_count", px_q.size(), 1);
    check_px("csn_abort_px", 1, 0, 16'h5678);

    // Unknown command swallows its data bytes.
    clear_q();
    send_cmd(8'h3A);
    send_dat(8'h05);
    send_dat(8'hFF);
    send_dat(8'hFF);
    settle();
    check("unk_px_count", px_q.size(), 0);
    check("unk_cmd", 32'(bus.cmd), 32'h3A);
    check("unk_cmd_count", cmd_q.size(), 1);

    // Panel reset pin restores the default window.
    send_cmd(8'h2A); send_dat(8'h00); send_dat(8'h04); send_dat(8'h00); send_dat(8'h05);
    @(negedge clk);
    bus.oled_resn = 1'b0;
    repeat (5) @(negedge clk);
    check("resn_cmd", 32'(bus.cmd), 32'd0);
    bus.oled_resn = 1'b1;
    repeat (4) @(negedge clk);
    clear_q();
    send_cmd(8'h2C);
    send_px(16'h00A1);
    send_px(16'h00A2);
    send_px(16'h00A3);
    settle();
    check_px("resn_px1", 0, 0, 16'h00A1);
    check_px("resn_px2", 1, 0, 16'h00A2);
    check_px("resn_px3", 2, 0, 16'h00A3);

    // Inverted column window runs through the modulo wrap.
    clear_q();
    send_cmd(8'h2A); send_dat(8'h00); send_dat(8'h06); send_dat(8'h00); send_dat(8'h01);
    send_cmd(8'h2C);
    for (int i = 1; i <= 5; i++) send_px(16'(i));
    settle();
    check_px("inv_px1", 6, 0, 1);
    check_px("inv_px2", 7, 0, 2);
    check_px("inv_px3", 0, 0, 3);
    check_px("inv_px4", 1, 0, 4);
    check_px("inv_px5", 6, 1, 5);

    // Asynchronous reset in the middle of a pixel: immediate clear, no strobe.
    clear_q();
    send_cmd(8'h2C);
    send_dat(8'hBE);
    spi_bits(1'b1, 8'hEF, 4);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("areset_cmd", 32'(bus.cmd), 32'd0);
    bus.oled_csn = 1'b1;
    repeat (6) @(negedge clk);
    resetn = 1'b1;
    settle();
    check("areset_px_count", px_q.size(), 0);
    bus.oled_csn = 1'b0;
    repeat (3) @(negedge clk);

    // MADCTL MX|MY: mirrored only when the feature is compiled in.
    clear_q();
    send_cmd(8'h36);
    send_dat(8'hC0);
    send_cmd(8'h2C);
    send_px(16'hBEEF);
    send_px(16'hCAFE);
    settle();
`ifdef ST7735_SINK_MADCTL_EN
    check_px("madctl_px1", XS - 1, YS - 1, 16'hBEEF);
    check_px("madctl_px2", XS - 2, YS - 1, 16'hCAFE);
`else
    check_px("madctl_px1", 0, 0, 16'hBEEF);
    check_px("madctl_px2", 1, 0, 16'hCAFE);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
